// File: rtl/divider_seq_pkg.sv
// rtl/divider_seq_pkg.sv - shared op/state encodings and width default for the sequential divider
package divider_seq_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // The high op bit selects remainder, the low op bit selects unsigned.
    function automatic logic op_is_rem(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/divider_seq_div_step.sv
// rtl/divider_seq_div_step.sv - one restoring-division iteration (shift, trial subtract, select)
//   rem       : partial remainder before this step (always < divisor)
//   quo       : dividend bits not yet consumed in the MSBs, quotient bits collected in the LSBs
//   divisor   : magnitude of the divisor
//   rem_next  : partial remainder after this step
//   quo_next  : quo shifted left with the new quotient bit in bit 0
module div_step
    import divider_seq_pkg::*;
#(
    parameter int Width = WIDTH_DEFAULT
) (
    input  logic [Width-1:0] rem,
    input  logic [Width-1:0] quo,
    input  logic [Width-1:0] divisor,
    output logic [Width-1:0] rem_next,
    output logic [Width-1:0] quo_next
);

    logic [Width:0]   shifted;
    logic [Width:0]   diff;
    logic [Width:0]   rem_wide;
    logic             cout;
    logic             unused_rem_msb;

    assign shifted = {rem, quo[Width-1]};

    // Width+1 bit adder: shifted + ~{0,divisor} + 1. The carry-out is set
    // exactly when shifted >= divisor, i.e. the trial difference is non-negative.
    assign {cout, diff} = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + {{(Width+1){1'b0}}, 1'b1};

    assign rem_wide = cout ? diff : shifted;

    // The remainder stays below the divisor, so the top bit of the selected
    // value is always zero and is dropped.
    assign rem_next       = rem_wide[Width-1:0];
    assign unused_rem_msb = rem_wide[Width];

    assign quo_next = {quo[Width-2:0], cout};

endmodule

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - multi-cycle restoring divider for DIV/DIVU/REM/REMU
//   clk, reset : clock and synchronous active-high reset
//   start      : request a new operation, only looked at while idle
//   op         : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b       : dividend and divisor, sampled on the accept edge only
//   busy       : high whenever the FSM is not idle
//   done       : one-cycle pulse when result becomes valid
//   result     : quotient or remainder, held until the next accepted start
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int Width = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] result
);

    localparam int CW = $clog2(Width + 1);

    state_e           state;
    logic [CW-1:0]    count;
    logic             rem_sel;
    logic             q_neg;
    logic             r_neg;
    logic [Width-1:0] rem;
    logic [Width-1:0] quo;
    logic [Width-1:0] divisor;
    logic [Width-1:0] rem_next;
    logic [Width-1:0] quo_next;

    op_e              op_in;
    logic             in_signed;
    logic             in_rem;
    logic             a_neg;
    logic             b_neg;
    logic [Width-1:0] a_mag;
    logic [Width-1:0] b_mag;
    logic             div_zero;
    logic             overflow;

    assign op_in     = op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign in_rem    = op_is_rem(op_in);
    assign a_neg     = in_signed & a[Width-1];
    assign b_neg     = in_signed & b[Width-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign div_zero  = (b == '0);
    assign overflow  = in_signed && (a == {1'b1, {(Width-1){1'b0}}}) && (b == '1);

    div_step #(.Width(Width)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rem_sel <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem_sel <= in_rem;
                        busy    <= 1'b1;
                        if (div_zero) begin
                            result <= in_rem ? a : '1;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (overflow) begin
                            result <= in_rem ? '0 : a;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            rem     <= '0;
                            quo     <= a_mag;
                            divisor <= b_mag;
                            q_neg   <= a_neg ^ b_neg;
                            r_neg   <= a_neg;
                            count   <= CW'(Width);
                            state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - 1'b1;
                    // The last step and the sign fix-up share one edge so done
                    // follows the final iteration without an extra cycle.
                    if (count == CW'(1)) begin
                        if (rem_sel) begin
                            result <= r_neg ? -rem_next : rem_next;
                        end else begin
                            result <= q_neg ? -quo_next : quo_next;
                        end
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - self-checking bench for divider_seq
module tb_divider_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors;
    int miscompares;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    divider_seq #(.Width(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : x;
        case (o)
            2'b00:   return 32'($signed(x) / $signed(y));
            2'b01:   return x / y;
            2'b10:   return 32'($signed(x) % $signed(y));
            default: return x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 0;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Drives start across one edge (the accept edge), then scrambles the
    // operands since they are only sampled on that edge. Returns #1 after it.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] expv, input int lat);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(expv);
        lat_q.push_back(lat);
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // n0 = edges already elapsed since the accept edge.
    task automatic wait_done(input string tag, input int n0);
        int n;
        logic [31:0] expv;
        int lat;
        n = n0;
        while (!done && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        expv = exp_q.pop_front();
        lat  = lat_q.pop_front();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_result"}, result, expv);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold"}, result, expv);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y, model(o, x, y), model_lat(o, x, y));
        wait_done(tag, 0);
    endtask

    initial begin
        int extra;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, issued back-to-back in the idle cycle after done.
        issue(2'b01, 32'd100, 32'd7, 32'd14, 32);
        wait_done("divu_100_7", 0);
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32);
        wait_done("remu_100_7", 0);
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        wait_done("div_m7_2", 0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        wait_done("rem_m7_2", 0);
        issue(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        wait_done("divu_by0", 0);
        issue(2'b11, 32'd5, 32'd0, 32'd5, 0);
        wait_done("remu_by0", 0);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        wait_done("div_ovf", 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        wait_done("rem_ovf", 0);
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
        wait_done("div_7_m2", 0);
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32);
        wait_done("divu_max_1", 0);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx;
            logic [31:0] ry;
            ro = 2'($urandom);
            rx = $urandom;
            ry = (i == 2) ? 32'($urandom_range(1, 255)) : $urandom;
            run_op($sformatf("rand%0d", i), ro, rx, ry);
        end

        // start pulsed mid-run must be ignored: one done, at the normal latency.
        issue(2'b01, 32'd1000, 32'd10, 32'd100, 32);
        repeat (4) @(posedge clk);
        #1;
        op = 2'b01; a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("start_in_run", 5);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("no_queued_start", extra, 0);

        // Reset in RUN aborts, and wins over a simultaneous start.
        issue(2'b01, 32'd100, 32'd7, 32'd14, 32);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        check("abort_no_done", extra, 0);

        // Divider still usable after the abort.
        run_op("post_abort_div", 2'b00, 32'hFFFF_FF9C, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The module SHALL have parameter Width, default 32, which sets the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request a new operation, sampled only in IDLE.
REQ-005 The module SHALL have port op, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The module SHALL have port a, input, Width bits: the dividend.
REQ-007 The module SHALL have port b, input, Width bits: the divisor.
REQ-008 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The module SHALL have port done, output, 1 bit: a one-cycle pulse marking result valid.
REQ-010 The module SHALL have port result, output, Width bits: the quotient or remainder, registered and held until the next accepted start.

Function
REQ-011 The module SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start (normal case); IDLE->DONE on start (special case); RUN->DONE when the iteration count reaches Width; DONE->IDLE unconditionally.
REQ-012 At the accept edge the module SHALL latch op, form |a| and |b| for signed ops (DIV/REM) or raw values for unsigned ops, record quotient and remainder signs, and load a counter with Width.
REQ-013 RUN SHALL perform one restoring step per cycle: remainder = (remainder<<1)|next dividend bit; trial = remainder - divisor computed at Width+1 bits; if trial is non-negative, remainder = trial and the quotient bit is 1, otherwise 0.
REQ-014 For start accepted at edge T, done SHALL be 1 in cycle T+Width+1 (T+33 at default Width) in the normal case and in cycle T+1 in special cases.
REQ-015 The DIV quotient sign SHALL be sign(a) XOR sign(b), and the REM remainder sign SHALL equal sign(a); negation is two's complement, applied when entering DONE.
REQ-016 For divide by zero (b==0), the module SHALL return all-ones for DIV/DIVU and a for REM/REMU, via the special path.
REQ-017 For signed overflow (DIV/REM, a==100..0, b==all-ones), the module SHALL return a for DIV and 0 for REM, via the special path.
REQ-018 start asserted in RUN or DONE SHALL be ignored, with no effect on the operation in progress and no queuing.
REQ-019 start in the cycle after done (IDLE) SHALL be accepted, so back-to-back operations carry no extra bubble.
REQ-020 result SHALL be written only on entry to DONE and SHALL hold its value in IDLE.
REQ-021 The a, b and op inputs SHALL be don't-care except in the accept cycle.

Reset
REQ-022 When reset=1 at a clock edge, the module SHALL set the state to IDLE, the counter to 0, and busy, done and result to 0.
REQ-023 Reset in RUN or DONE SHALL abort the operation with no done pulse, and reset SHALL take priority over a simultaneous start.

Structure
REQ-024 The op encodings, state encodings and the Width default SHALL live in a shared divider package/header, which the decoder and datapath also include.
REQ-025 There SHALL be one sub-module, div_step: the combinational compare/subtract/shift for one iteration, built on the team adder (Width+1 bits, inverted divisor, cin=1) so that the carry-out gives the non-negative test.
REQ-026 The FSM, counter, sign fix-up and result register SHALL reside in divider_seq.

Verification
REQ-027 The bench SHALL apply DIVU a=100, b=7 at T and require done in T+33 with result=14; REMU with the same operands SHALL give result=2.
REQ-028 The bench SHALL apply DIV a=-7 (0xFFFFFFF9), b=2 and require 0xFFFFFFFD; REM with the same operands SHALL give 0xFFFFFFFF.
REQ-029 The bench SHALL apply DIVU a=5, b=0 and require done at T+1 with result=0xFFFFFFFF; REMU a=5, b=0 SHALL give result=5.
REQ-030 The bench SHALL apply DIV a=0x80000000, b=0xFFFFFFFF and require done at T+1 with result=0x80000000; REM with the same operands SHALL give 0.
REQ-031 The bench SHALL pulse start at T+5 while in RUN and require no effect (one done only, at T+33); reset at T+10 SHALL give busy=0, done=0, result=0 the next cycle and no later done.
REQ-032 The bench SHALL assert start in the IDLE cycle right after done, require it accepted, and require the second result correct at +33.
